// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division, both on
// operand magnitudes with a final two's-complement sign fix in the FIX state.
// Optional macro MULDIV_FAST_MULT_EN: multiplies computed in one cycle with a
// combinational multiplier; divides stay iterative.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] rs_in,
  input  logic [WIDTH-1:0] rt_in,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] write_data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned W2     = 2 * WIDTH;
  localparam int unsigned CNT_W  = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_step;
  logic               w_fix;
  logic               w_idle;
  logic               w_fast;

  logic [CNT_W-1:0]   r_cnt;
  logic [W2-1:0]      r_acc;
  logic [WIDTH-1:0]   r_m;
  logic               r_op_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_msum;
  logic [W2-1:0]      w_mul_next;
  logic [WIDTH:0]     w_dshift;
  logic [WIDTH:0]     w_ddiff;
  logic [W2-1:0]      w_div_next;
  logic [W2-1:0]      w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign busy   = r_busy;
  assign done   = r_done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

  // Operand sign handling: signed ops work on magnitudes
  assign w_signed = ~op_in[0];
  assign w_rs_neg = w_signed & rs_in[WIDTH-1];
  assign w_rt_neg = w_signed & rt_in[WIDTH-1];
  assign w_a_mag  = w_rs_neg ? (~rs_in + WIDTH'(1)) : rs_in;
  assign w_b_mag  = w_rt_neg ? (~rt_in + WIDTH'(1)) : rt_in;

  // Multiply step: conditionally add multiplicand to upper half, shift right
  assign w_msum     = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

  // Divide step: shift remainder/quotient left, subtract divisor, restore if negative
  assign w_dshift   = r_acc[W2-1:WIDTH-1];
  assign w_ddiff    = w_dshift - {1'b0, r_m};
  assign w_div_next = w_ddiff[WIDTH] ? {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_ddiff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  // Sign correction of the finished magnitude results
  assign w_prod = r_neg_q ? (~r_acc + W2'(1)) : r_acc;
  assign w_quot = r_dz ? {WIDTH{1'b1}}
                       : (r_neg_q ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0]);
  assign w_rem  = r_neg_r ? (~r_acc[W2-1:WIDTH] + WIDTH'(1)) : r_acc[W2-1:WIDTH];

`ifdef MULDIV_FAST_MULT_EN
  logic [W2-1:0] w_rs_ext;
  logic [W2-1:0] w_rt_ext;
  logic [W2-1:0] w_prod_fast;

  // Single-cycle product; sign- or zero-extension makes the low 2W bits exact
  assign w_fast      = ~op_in[1];
  assign w_rs_ext    = {{WIDTH{w_signed & rs_in[WIDTH-1]}}, rs_in};
  assign w_rt_ext    = {{WIDTH{w_signed & rt_in[WIDTH-1]}}, rt_in};
  assign w_prod_fast = w_rs_ext * w_rt_ext;
`else
  assign w_fast = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and control strobes
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_fix        = 1'b0;
    w_idle       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = w_fast ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) w_state_next = S_FIX;
      end
      S_FIX: begin
        w_fix        = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath, HI/LO and registered status outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_m      <= '0;
      r_op_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      r_done <= w_fix;
      if (w_idle && hi_we) r_hi <= write_data_in;
      if (w_idle && lo_we) r_lo <= write_data_in;
      if (w_accept) begin
        r_op_div <= op_in[1];
        r_cnt    <= '0;
        r_neg_q  <= w_rs_neg ^ w_rt_neg;
        r_neg_r  <= w_rs_neg;
        r_dz     <= op_in[1] & (rt_in == '0);
        // Divide: divisor held, dividend shifts in; multiply: multiplicand held
        r_m      <= op_in[1] ? w_b_mag : w_a_mag;
        r_acc    <= {{WIDTH{1'b0}}, (op_in[1] ? w_a_mag : w_b_mag)};
`ifdef MULDIV_FAST_MULT_EN
        if (w_fast) begin
          r_acc   <= w_prod_fast;
          r_neg_q <= 1'b0;
        end
`endif
      end
      if (w_step) begin
        r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
        r_acc <= r_op_div ? w_div_next : w_mul_next;
      end
      if (w_fix) begin
        if (r_op_div) begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end else begin
          r_hi <= w_prod[W2-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed ops plus a few random ones,
// expected HI/LO pushed to a scoreboard at issue and popped on done.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif
  localparam int DLAT = 33;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op_in;
  logic [31:0] rs_in;
  logic [31:0] rt_in;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] write_data_in;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .op_in         (op_in),
    .rs_in         (rs_in),
    .rt_in         (rt_in),
    .hi_we         (hi_we),
    .lo_we         (lo_we),
    .write_data_in (write_data_in),
    .busy          (busy),
    .done          (done),
    .hi_out        (hi_out),
    .lo_out        (lo_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: disturb with start/MTHI while busy, 2: MTHI on accept edge
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int mode);
    exp_t        e;
    int          lat;
    int          exp_lat;
    bit          unstable;
    logic [31:0] h0;
    logic [31:0] l0;
    e.hi = ehi; e.lo = elo; e.tag = tag;
    sb.push_back(e);
    exp_lat = op[1] ? DLAT : MLAT;
    @(negedge clock);
    start = 1'b1; op_in = op; rs_in = a; rt_in = b;
    if (mode == 2) begin hi_we = 1'b1; write_data_in = 32'h0000_DEAD; end
    @(negedge clock);
    start = 1'b0; hi_we = 1'b0;
    op_in = 2'($urandom); rs_in = $urandom; rt_in = $urandom;
    if (mode == 2) check({tag, " mthi_on_accept"}, hi_out, 32'h0000_DEAD);
    h0 = hi_out; l0 = lo_out;
    lat = 0; unstable = 1'b0;
    if (exp_lat > 1) check({tag, " busy"}, 32'(busy), 32'd1);
    while (1) begin
      if (lat > 0 || !done) begin
        @(negedge clock);
        lat++;
      end
      if (mode == 1) begin
        start = (lat == 10);
        if (lat == 10) begin op_in = 2'b01; rs_in = 32'd9; rt_in = 32'd9; end
        hi_we = (lat == 12);
        write_data_in = 32'h0000_1234;
      end
      if (done || lat >= 100) break;
      if (hi_out !== h0 || lo_out !== l0) unstable = 1'b1;
    end
    start = 1'b0; hi_we = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " hold"}, 32'(unstable), 32'd0);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, " HI"}, hi_out, e.hi);
      check({e.tag, " LO"}, lo_out, e.lo);
    end
    @(negedge clock);
    check({tag, " done_width"}, 32'(done), 32'd0);
  endtask

  task automatic count_dones(input int n, output int k);
    k = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (done) k++;
    end
  endtask

  initial begin
    int          k;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic [31:0] prev_hi;

    reset = 1'b0; start = 1'b0; op_in = 2'b00; rs_in = '0; rt_in = '0;
    hi_we = 1'b0; lo_we = 1'b0; write_data_in = '0;
    repeat (2) @(negedge clock);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi_out, 32'd0);
    check("reset lo", lo_out, 32'd0);
    reset = 1'b1;

    run_op("MULT -3*7",   2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("MULTU fffffffd*7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'd6, 32'hFFFF_FFEB, 0);
    run_op("MULT min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 0);
    run_op("DIV -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("DIVU 100/7",  2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_op("DIVU 5/0",    2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
    run_op("DIV -5/0",    2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
    run_op("DIV min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);

    // start and MTHI while busy are ignored; exactly one done
    run_op("DIV 1000/-3 disturbed", 2'b10, 32'd1000, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FEB3, 1);
    count_dones(40, k);
    check("no extra done", 32'(k), 32'd0);

    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (b == 32'd0) b = 32'd3;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
      case (op)
        2'b00: begin
          p = 64'(longint'($signed(a)) * longint'($signed(b)));
          run_op("rand MULT", op, a, b, p[63:32], p[31:0], 0);
        end
        2'b01: begin
          p = {32'd0, a} * {32'd0, b};
          run_op("rand MULTU", op, a, b, p[63:32], p[31:0], 0);
        end
        2'b10: run_op("rand DIV", op, a, b, 32'($signed(a) % $signed(b)),
                      32'($signed(a) / $signed(b)), 0);
        default: run_op("rand DIVU", op, a, b, a % b, a / b, 0);
      endcase
    end

    // MTLO in idle
    prev_hi = hi_out;
    @(negedge clock);
    lo_we = 1'b1; write_data_in = 32'h0000_CAFE;
    @(negedge clock);
    lo_we = 1'b0;
    check("MTLO lo", lo_out, 32'h0000_CAFE);
    check("MTLO hi untouched", hi_out, prev_hi);

    // MTHI on the accept edge applies, then the result overwrites it
    run_op("MULTU 3*4 with MTHI", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 2);

    // Give HI/LO nonzero values, then abort mid-RUN with reset
    run_op("DIVU 100/7 pre", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    @(negedge clock);
    start = 1'b1; op_in = 2'b11; rs_in = 32'd77; rt_in = 32'd5;
    @(negedge clock);
    start = 1'b0;
    repeat (15) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort hi", hi_out, 32'd0);
    check("abort lo", lo_out, 32'd0);
    count_dones(40, k);
    check("abort no done", 32'(k), 32'd0);
    run_op("MULTU 3*4 after abort", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 0);
    run_op("MULT 3*4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 0);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit holding the architectural HI/LO registers of the MIPS datapath. Sits directly downstream of the register file: it consumes the two read-port values (rs, rt) for MULT/MULTU/DIV/DIVU, runs a multi-cycle shift-add or restoring-divide sequence, and exposes HI/LO to the writeback mux for MFHI/MFLO. The control unit stalls the pipeline on `busy`.

## Interface
Parameters:
- `WIDTH`, 32: operand width. HI/LO are each `WIDTH` bits. Only 32 is verified.

Ports:
- `clock` in 1: sole clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the rising edge of `clock`.
- `start` in 1: launch operation; accepted only when `busy`=0.
- `op_in` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `rs_in` in 32: operand A (dividend/multiplicand), from regfile read port 1.
- `rt_in` in 32: operand B (divisor/multiplier), from regfile read port 2.
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `write_data_in` in 32: MTHI/MTLO data.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse when HI/LO are updated by an operation.
- `hi_out` out 32: HI register, driven directly from flop.
- `lo_out` out 32: LO register, driven directly from flop.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE + `start`=1: latch `op_in`; for signed ops latch |rs|, |rt| and result signs (product sign = sign(rs) XOR sign(rt); quotient sign likewise; remainder sign = sign(rs)); clear 6-bit iteration count; go RUN; `busy`=1.
- RUN: one radix-2 step per cycle (multiply: conditional add + 64-bit right shift; divide: restoring shift-subtract). After 32 steps go FIX.
- FIX: apply sign correction (two's-complement negate), write HI/LO, pulse `done`, clear `busy`, go IDLE.
- Multiply: {HI,LO} = 64-bit product. Divide: LO = quotient, HI = remainder, truncation toward zero.
- Divide by zero (rt=0): LO=32'hFFFF_FFFF, HI=rs_in, same latency, no exception.
- Signed 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- `start` while `busy`=1: ignored, no side effects.
- `hi_we`/`lo_we` in IDLE: update HI/LO at the edge with `write_data_in`. While `busy`=1: ignored. Same edge as accepted `start`: write applies, operation also launches; final result overwrites.
- `reset` low at any edge, including mid-RUN: abort, state IDLE, all outputs to reset values.

## Timing
- Reset values: `busy`=0, `done`=0, `hi_out`=0, `lo_out`=0, state IDLE.
- `start` accepted at edge N → `busy`=1 after edge N; RUN steps at edges N+1..N+32; FIX writes HI/LO at edge N+33, `done`=1 and `busy`=0 for the cycle following edge N+33.
- Latency: 33 cycles start-edge to result. Back-to-back: `start` held during the `done` cycle is accepted at edge N+34.
- HI/LO are stable and hold the previous values throughout `busy`; readers see new values only from the `done` cycle on.
- Operands are captured at the accept edge; `rs_in`/`rt_in` may change freely afterwards.

## Configuration
- `MULDIV_FAST_MULT_EN` defined: MULT/MULTU bypass RUN; the full product is computed combinationally at the accept edge N, registered to FIX state, HI/LO written at edge N+1, `done` in the following cycle (latency 1). Divides unchanged (33 cycles).
- Not defined: multiplies use the iterative path, 33-cycle latency, no wide multiplier inferred.

## Test plan
- Reset: hold `reset`=0 two cycles → `busy`=0, `done`=0, `hi_out`=`lo_out`=0.
- MULT rs=32'hFFFF_FFFD (−3), rt=7 → after 33 cycles HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB; MULTU same operands → HI=6, LO=32'hFFFF_FFEB; `done` exactly one cycle.
- DIV rs=−7, rt=2 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; DIVU 100/7 → LO=14, HI=2; DIVU 5/0 → LO=32'hFFFF_FFFF, HI=5.
- `start` pulsed at cycle 10 of an in-flight DIV and `hi_we` with 32'h1234 at cycle 12 → both ignored, original result unchanged, single `done`.
- `reset` low at RUN step 15 → next cycle IDLE, HI/LO=0, no `done`; new MULTU 3×4 then gives LO=12, HI=0.
- MTLO 32'hCAFE in IDLE → `lo_out`=32'hCAFE next cycle; with `MULDIV_FAST_MULT_EN`, MULT 3×4 → `done` one cycle after accept, LO=12.
